// File: rtl/accel_pkg.sv
// Shared accelerator definitions: accumulator width, default column count
// and the signed saturating add used wherever partial sums are combined.
// No ports; imported by the psum accumulator and any other PE-side logic.
package accel_pkg;

  localparam int ACC_WIDTH    = 32;
  localparam int DEF_NUM_COLS = 4;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef struct packed {
    logic clip;
    acc_t sum;
  } sat_res_t;

  // Add in ACC_WIDTH+1 bits; disagreement between the two top bits means the
  // true result does not fit, so clamp toward the sign of the wide result.
  function automatic sat_res_t sat_add(input acc_t a, input acc_t b);
    logic signed [ACC_WIDTH:0] s;
    sat_res_t r;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    r.clip = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    if (r.clip) begin
      r.sum = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      r.sum = s[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_out_fifo.sv
// Synchronous result FIFO with occupancy count and no read bypass.
// Ports: push/push_data in, pop in, head (zero when empty), empty, count,
// dropped (push refused because full with no same-cycle pop).
module psum_out_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dropped
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_accumulator.sv
// Systolic-array output accumulator: de-skews bottom-row partial sums,
// accumulates K-tiles per buffer row with saturation, and streams final rows
// (optionally ReLU-clamped) through a small output FIFO.
// Ports: in_valid/in_psum/in_addr/in_first/in_last (skewed input row),
// relu_en, out_valid/out_ready/out_data (result stream), sat_flag and ovf_err
// (sticky status), fifo_count (occupancy).
module psum_accumulator #(
  parameter int NUM_COLS   = accel_pkg::DEF_NUM_COLS,
  parameter int ACC_WIDTH  = accel_pkg::ACC_WIDTH,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NUM_COLS*ACC_WIDTH-1:0] in_psum,
  input  logic [$clog2(DEPTH)-1:0]      in_addr,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic                          relu_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_COLS*ACC_WIDTH-1:0] out_data,
  output logic                          sat_flag,
  output logic                          ovf_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import accel_pkg::*;

  localparam int AW  = $clog2(DEPTH);
  localparam int RW  = NUM_COLS*ACC_WIDTH;
  localparam int LAT = NUM_COLS-1;

  // Aligned row, valid combinationally LAT cycles after in_valid.
  logic [RW-1:0] aln_psum;
  logic          aln_valid;
  logic          aln_first;
  logic          aln_last;
  logic [AW-1:0] aln_addr;

  // Lane c arrives c cycles late, so it needs LAT-c more cycles to line up.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
    localparam int D = NUM_COLS-1-c;
    if (D == 0) begin : g_pass
      assign aln_psum[c*ACC_WIDTH +: ACC_WIDTH] = in_psum[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] sr [D];
      always_ff @(posedge clk) begin
        sr[0] <= in_psum[c*ACC_WIDTH +: ACC_WIDTH];
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
      assign aln_psum[c*ACC_WIDTH +: ACC_WIDTH] = sr[D-1];
    end
  end

  if (LAT == 0) begin : g_ctl_pass
    assign aln_valid = in_valid;
    assign aln_first = in_first;
    assign aln_last  = in_last;
    assign aln_addr  = in_addr;
  end else begin : g_ctl_dly
    logic [LAT-1:0] v_sr;
    logic [LAT-1:0] f_sr;
    logic [LAT-1:0] l_sr;
    logic [AW-1:0]  a_sr [LAT];
    always_ff @(posedge clk) begin
      if (rst) begin
        v_sr <= '0;
      end else begin
        v_sr[0] <= in_valid;
        for (int i = 1; i < LAT; i++) v_sr[i] <= v_sr[i-1];
      end
      f_sr[0] <= in_first;
      l_sr[0] <= in_last;
      a_sr[0] <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        f_sr[i] <= f_sr[i-1];
        l_sr[i] <= l_sr[i-1];
        a_sr[i] <= a_sr[i-1];
      end
    end
    assign aln_valid = v_sr[LAT-1];
    assign aln_first = f_sr[LAT-1];
    assign aln_last  = l_sr[LAT-1];
    assign aln_addr  = a_sr[LAT-1];
  end

  // Stage A: registered aligned row.
  logic          a_vld;
  logic          a_first;
  logic          a_last;
  logic [AW-1:0] a_addr;
  logic [RW-1:0] a_psum;

  always_ff @(posedge clk) begin
    if (rst) a_vld <= 1'b0;
    else     a_vld <= aln_valid;
    a_first <= aln_first;
    a_last  <= aln_last;
    a_addr  <= aln_addr;
    a_psum  <= aln_psum;
  end

  // Accumulation buffer is read and written in the same stage, so a row that
  // follows directly behind another to the same addr already sees the update.
  logic [RW-1:0] acc_buf [DEPTH];
  logic [RW-1:0] sum;
  logic          clip_any;

  always_comb begin
    sum      = '0;
    clip_any = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      acc_t     base;
      sat_res_t r;
      base = a_first ? '0 : acc_buf[a_addr][c*ACC_WIDTH +: ACC_WIDTH];
      r    = sat_add(base, a_psum[c*ACC_WIDTH +: ACC_WIDTH]);
      sum[c*ACC_WIDTH +: ACC_WIDTH] = r.sum;
      clip_any = clip_any | r.clip;
    end
  end

  // Stage B: finished rows waiting to enter the FIFO.
  logic          b_vld;
  logic [RW-1:0] b_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld    <= 1'b0;
      sat_flag <= 1'b0;
      for (int d = 0; d < DEPTH; d++) acc_buf[d] <= '0;
    end else begin
      b_vld <= a_vld && a_last;
      if (a_vld && !a_last) acc_buf[a_addr] <= sum;
      if (a_vld && clip_any) sat_flag <= 1'b1;
    end
    b_sum <= sum;
  end

  logic [RW-1:0] push_row;

  always_comb begin
    push_row = b_sum;
    if (relu_en) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (b_sum[c*ACC_WIDTH + ACC_WIDTH-1]) push_row[c*ACC_WIDTH +: ACC_WIDTH] = '0;
      end
    end
  end

  logic fifo_empty;
  logic drop;

  psum_out_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (b_vld),
    .push_data (push_row),
    .pop       (out_valid && out_ready),
    .head      (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (drop)
  );

  assign out_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst)       ovf_err <= 1'b0;
    else if (drop) ovf_err <= 1'b1;
  end

endmodule
